weight_buf_loader: RTL and testbench
====================================

# weight_buf_loader

Fills the two ping-pong weight buffers (A/B) consumed by the PE array. It takes per-layer load descriptors, fetches the weight words from memory in bursts, and writes them into the next free buffer. It raises `bufA_loaded` / `bufB_loaded` toward `pe_controller` and frees each buffer when that controller reports `layer_done`. Buffers are filled and consumed strictly in order A, B, A, …

## Interface
- `DATA_W`, 64, weight word width in bits.
- `ADDR_W`, 32, memory byte-address width.
- `BUF_AW`, 10, buffer address width; depth `DEPTH` = 2^BUF_AW words.
- `MAX_BURST`, 16, maximum beats per memory read request (power of two, ≤ 2^BUF_AW).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `desc_valid`  in  1  load descriptor offered.
- `desc_ready`  out  1  descriptor accepted when high together with `desc_valid`.
- `desc_base`  in  ADDR_W  start byte address; aligned to DATA_W/8.
- `desc_words`  in  BUF_AW+1  number of words to load; values > DEPTH saturate to DEPTH.
- `rd_req_valid`  out  1  memory read request.
- `rd_req_ready`  in  1  memory accepts request.
- `rd_req_addr`  out  ADDR_W  burst start byte address.
- `rd_req_len`  out  $clog2(MAX_BURST)+1  beats in burst, 1..MAX_BURST.
- `rd_data_valid`  in  1  read data beat; no backpressure.
- `rd_data`  in  DATA_W  read data.
- `wbuf_we`  out  1  buffer write strobe.
- `wbuf_sel`  out  1  target buffer: 0 = A, 1 = B.
- `wbuf_addr`  out  BUF_AW  word index within the buffer.
- `wbuf_wdata`  out  DATA_W  write data.
- `bufA_loaded`, `bufB_loaded`  out  1 each  buffer holds a complete layer.
- `layer_done`  in  1  one-cycle pulse; consumer releases the buffer it was using.
- `busy`  out  1  FSM not in IDLE.
- `err`  out  1  one-cycle protocol-error pulse.

## Operation
- State: `fill_ptr` (next buffer to fill), `rel_ptr` (next buffer to release), `loaded[1:0]`, `remaining` words, `cur_addr`, `wr_idx`, `beat_cnt`.
- FSM states:
  - IDLE
    - `desc_ready` = !loaded[fill_ptr].
    - On handshake: latch base, saturated count, `wr_idx` = 0.
    - Go to MARK if count = 0, else REQ.
  - REQ
    - `rd_req_valid` = 1, `rd_req_len` = min(remaining, MAX_BURST), `rd_req_addr` = cur_addr.
    - On `rd_req_ready`: set `beat_cnt` = len, `remaining` -= len, `cur_addr` += len·DATA_W/8; go to DATA.
  - DATA
    - Each `rd_data_valid` beat is written to `wbuf_addr` = `wr_idx`, `wbuf_sel` = fill_ptr; `wr_idx`++ and `beat_cnt`--.
    - On the last beat of the burst: go to REQ if remaining ≠ 0, else MARK.
  - MARK
    - Set loaded[fill_ptr], toggle `fill_ptr`, go to IDLE.
- Only one burst is outstanding at a time.
- Release:
  - `layer_done` with loaded[rel_ptr] = 1: clear loaded[rel_ptr], toggle `rel_ptr`.
  - `layer_done` with loaded[rel_ptr] = 0: ignored, `err` pulses.
- `bufA_loaded` = loaded[0], `bufB_loaded` = loaded[1].
- `rd_data_valid` outside DATA: beat dropped, no write, `err` pulses.
- Release and MARK in the same cycle act on different buffers; both take effect. A release in the same cycle as MARK of the same buffer cannot occur, because MARK requires that buffer to be unloaded.
- Wrap-around: `wr_idx` never exceeds DEPTH−1 because the count is saturated. `cur_addr` wraps modulo 2^ADDR_W.

## Timing
- Reset: state IDLE; fill_ptr = rel_ptr = 0; loaded = 00.
- Every output is 0 during and after reset, except `desc_ready`, which is 1 in the first cycle after reset.
- Descriptor accepted at cycle T → `rd_req_valid` high at T+1.
- `rd_req_valid` and its address/length stay stable until `rd_req_ready`.
- Data beat at cycle t → `wbuf_we` with its data at t+1 (one register stage).
- Last beat at t → MARK at t+1 (final write also at t+1) → loaded bit high and `desc_ready` re-evaluated at t+2.
- Zero-length descriptor at T → loaded bit high at T+2, with no memory traffic.
- `layer_done` at t → loaded bit low at t+1. If the FSM is in IDLE waiting on that buffer, `desc_ready` goes high at t+1.
- `rst` mid-load discards the load. Beats still in flight after reset are dropped and flagged `err`.

## Test plan
- Single load: desc_words = 40, base 0x1000, MAX_BURST 16.
  - Expect requests (0x1000, 16), (0x1080, 16), (0x1100, 8).
  - Expect 40 writes to A at indices 0–39.
  - `bufA_loaded` rises 2 cycles after the last beat.
- Ping-pong: two descriptors back-to-back.
  - The second fills B.
  - A third descriptor is held (`desc_ready` = 0) until `layer_done`; then A is cleared and the third load targets A.
- Saturation / zero length:
  - desc_words = 1500 with BUF_AW = 10 → exactly 1024 writes.
  - desc_words = 0 → loaded bit at T+2, no `rd_req_valid`.
- Backpressure: hold `rd_req_ready` = 0 for 7 cycles → request fields stable throughout; a single handshake follows.
- Protocol errors:
  - `layer_done` with both buffers empty → `err` pulse, `rel_ptr` unchanged.
  - Stray `rd_data_valid` in IDLE → `err` pulse, no `wbuf_we`.
- Reset mid-burst: assert `rst` after 5 of 16 beats → all outputs 0, loaded = 00. Remaining beats produce no writes. A fresh descriptor afterwards fills A correctly.

Source files
------------

// File: rtl/weight_buf_loader.sv
// Ping-pong weight buffer loader: turns per-layer descriptors into burst reads
// and fills buffers A/B strictly in order, releasing them on layer_done.
module weight_buf_loader #(
    parameter  int DATA_W    = 64,
    parameter  int ADDR_W    = 32,
    parameter  int BUF_AW    = 10,
    parameter  int MAX_BURST = 16,
    localparam int LEN_W     = $clog2(MAX_BURST) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [ADDR_W-1:0] desc_base,
    input  logic [BUF_AW:0]   desc_words,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [ADDR_W-1:0] rd_req_addr,
    output logic [LEN_W-1:0]  rd_req_len,
    input  logic              rd_data_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wbuf_we,
    output logic              wbuf_sel,
    output logic [BUF_AW-1:0] wbuf_addr,
    output logic [DATA_W-1:0] wbuf_wdata,
    output logic              bufA_loaded,
    output logic              bufB_loaded,
    input  logic              layer_done,
    output logic              busy,
    output logic              err
);

    localparam int DEPTH = 1 << BUF_AW;
    localparam int BYTES = DATA_W / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_MARK = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              fill_ptr_q, fill_ptr_d;
    logic              rel_ptr_q, rel_ptr_d;
    logic [1:0]        loaded_q, loaded_d;
    logic [BUF_AW:0]   remaining_q, remaining_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [BUF_AW-1:0] wr_idx_q, wr_idx_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              wbuf_we_q, wbuf_we_d;
    logic              wbuf_sel_q, wbuf_sel_d;
    logic [BUF_AW-1:0] wbuf_addr_q, wbuf_addr_d;
    logic [DATA_W-1:0] wbuf_wdata_q, wbuf_wdata_d;
    logic              err_q, err_d;

    logic [LEN_W-1:0]  burst_len;
    logic [BUF_AW:0]   desc_count;
    logic              desc_hs;

    // Oversized descriptors are clamped to the buffer depth, which also keeps
    // wr_idx inside the buffer without any extra bounds logic.
    assign desc_count = (desc_words > (BUF_AW+1)'(DEPTH)) ? (BUF_AW+1)'(DEPTH) : desc_words;
    assign burst_len  = (remaining_q >= (BUF_AW+1)'(MAX_BURST)) ? LEN_W'(MAX_BURST)
                                                                : LEN_W'(remaining_q);
    assign desc_hs    = (state_q == ST_IDLE) && !loaded_q[fill_ptr_q] && desc_valid;

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned,
        // which is what keeps this block from inferring latches.
        state_d      = state_q;
        fill_ptr_d   = fill_ptr_q;
        rel_ptr_d    = rel_ptr_q;
        loaded_d     = loaded_q;
        remaining_d  = remaining_q;
        cur_addr_d   = cur_addr_q;
        wr_idx_d     = wr_idx_q;
        beat_cnt_d   = beat_cnt_q;
        wbuf_we_d    = 1'b0;
        wbuf_sel_d   = wbuf_sel_q;
        wbuf_addr_d  = wbuf_addr_q;
        wbuf_wdata_d = wbuf_wdata_q;
        err_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (desc_hs) begin
                    cur_addr_d  = desc_base;
                    remaining_d = desc_count;
                    wr_idx_d    = '0;
                    state_d     = (desc_count == '0) ? ST_MARK : ST_REQ;
                end
            end
            ST_REQ: begin
                if (rd_req_ready) begin
                    beat_cnt_d  = burst_len;
                    remaining_d = remaining_q - (BUF_AW+1)'(burst_len);
                    cur_addr_d  = cur_addr_q + ADDR_W'(burst_len) * ADDR_W'(BYTES);
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rd_data_valid) begin
                    wbuf_we_d    = 1'b1;
                    wbuf_sel_d   = fill_ptr_q;
                    wbuf_addr_d  = wr_idx_q;
                    wbuf_wdata_d = rd_data;
                    wr_idx_d     = wr_idx_q + BUF_AW'(1);
                    beat_cnt_d   = beat_cnt_q - LEN_W'(1);
                    if (beat_cnt_q == LEN_W'(1)) begin
                        state_d = (remaining_q != '0) ? ST_REQ : ST_MARK;
                    end
                end
            end
            default: begin
                loaded_d[fill_ptr_q] = 1'b1;
                fill_ptr_d           = ~fill_ptr_q;
                state_d              = ST_IDLE;
            end
        endcase

        // MARK only targets an unloaded buffer, so it never collides with a release.
        if (layer_done) begin
            if (loaded_q[rel_ptr_q]) begin
                loaded_d[rel_ptr_q] = 1'b0;
                rel_ptr_d           = ~rel_ptr_q;
            end else begin
                err_d = 1'b1;
            end
        end

        if (rd_data_valid && (state_q != ST_DATA)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // the pre-edge values, independent of statement order.
        if (rst) begin
            state_q      <= ST_IDLE;
            fill_ptr_q   <= 1'b0;
            rel_ptr_q    <= 1'b0;
            loaded_q     <= 2'b00;
            remaining_q  <= '0;
            cur_addr_q   <= '0;
            wr_idx_q     <= '0;
            beat_cnt_q   <= '0;
            wbuf_we_q    <= 1'b0;
            wbuf_sel_q   <= 1'b0;
            wbuf_addr_q  <= '0;
            wbuf_wdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_ptr_q   <= fill_ptr_d;
            rel_ptr_q    <= rel_ptr_d;
            loaded_q     <= loaded_d;
            remaining_q  <= remaining_d;
            cur_addr_q   <= cur_addr_d;
            wr_idx_q     <= wr_idx_d;
            beat_cnt_q   <= beat_cnt_d;
            wbuf_we_q    <= wbuf_we_d;
            wbuf_sel_q   <= wbuf_sel_d;
            wbuf_addr_q  <= wbuf_addr_d;
            wbuf_wdata_q <= wbuf_wdata_d;
            err_q        <= err_d;
        end
    end

    // Outputs are forced low while rst is high, before the synchronous reset lands.
    assign desc_ready   = !rst && (state_q == ST_IDLE) && !loaded_q[fill_ptr_q];
    assign rd_req_valid = !rst && (state_q == ST_REQ);
    assign rd_req_addr  = rd_req_valid ? cur_addr_q : '0;
    assign rd_req_len   = rd_req_valid ? burst_len : '0;
    assign wbuf_we      = !rst && wbuf_we_q;
    assign wbuf_sel     = !rst && wbuf_sel_q;
    assign wbuf_addr    = rst ? '0 : wbuf_addr_q;
    assign wbuf_wdata   = rst ? '0 : wbuf_wdata_q;
    assign bufA_loaded  = !rst && loaded_q[0];
    assign bufB_loaded  = !rst && loaded_q[1];
    assign busy         = !rst && (state_q != ST_IDLE);
    assign err          = !rst && err_q;

endmodule

// File: tb/tb_weight_buf_loader.sv
// Randomized bench for weight_buf_loader: a memory responder plus a queue-based
// model of buffer occupancy and expected writes.
module tb_weight_buf_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        desc_valid, desc_ready;
    logic [31:0] desc_base;
    logic [10:0] desc_words;
    logic        rd_req_valid, rd_req_ready;
    logic [31:0] rd_req_addr;
    logic [4:0]  rd_req_len;
    logic        rd_data_valid;
    logic [63:0] rd_data;
    logic        wbuf_we, wbuf_sel;
    logic [9:0]  wbuf_addr;
    logic [63:0] wbuf_wdata;
    logic        bufA_loaded, bufB_loaded;
    logic        layer_done, busy, err;

    weight_buf_loader dut (
        .clk(clk), .rst(rst),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_base(desc_base), .desc_words(desc_words),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .wbuf_we(wbuf_we), .wbuf_sel(wbuf_sel),
        .wbuf_addr(wbuf_addr), .wbuf_wdata(wbuf_wdata),
        .bufA_loaded(bufA_loaded), .bufB_loaded(bufB_loaded),
        .layer_done(layer_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [9:0]  idx;
        logic [63:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   wr_count = 0;

    // Reference model of buffer occupancy
    logic       fill_m, rel_m;
    logic [1:0] loaded_m;
    int         idx_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wbuf_we === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", wbuf_we, 1'b0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_sel", wbuf_sel, e.sel);
                check("wr_idx", wbuf_addr, e.idx);
                check("wr_data", wbuf_wdata, e.data);
            end
        end
    end

    task automatic model_reset();
        fill_m   = 1'b0;
        rel_m    = 1'b0;
        loaded_m = 2'b00;
    endtask

    task automatic do_release();
        logic exp_err;
        layer_done = 1'b1;
        @(negedge clk);
        layer_done = 1'b0;
        if (loaded_m[rel_m]) begin
            loaded_m[rel_m] = 1'b0;
            rel_m           = ~rel_m;
            exp_err         = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
        check("rel_err", err, exp_err);
        check("rel_loaded", {bufB_loaded, bufA_loaded}, loaded_m);
    endtask

    task automatic stray_beat();
        rd_data_valid = 1'b1;
        rd_data       = {$urandom, $urandom};
        @(negedge clk);
        rd_data_valid = 1'b0;
        check("stray_err", err, 1'b1);
        check("stray_no_we", wbuf_we, 1'b0);
    endtask

    task automatic send_beat(input int gap);
        wr_t e;
        repeat (gap) @(negedge clk);
        rd_data_valid = 1'b1;
        rd_data       = {$urandom, $urandom};
        e.sel  = fill_m;
        e.idx  = 10'(idx_m);
        e.data = rd_data;
        exp_q.push_back(e);
        idx_m++;
        @(negedge clk);
        rd_data_valid = 1'b0;
    endtask

    task automatic serve_req(input logic [31:0] exp_addr, input int exp_len, input int stall);
        int w = 0;
        while (rd_req_valid !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("req_latency", w, 0);
        if (rd_req_valid !== 1'b1) begin
            $display("FAIL req_timeout: got no rd_req_valid expected request at %0h", exp_addr);
            $fatal(1, "request timeout");
        end
        check("req_addr", rd_req_addr, exp_addr);
        check("req_len", rd_req_len, exp_len);
        repeat (stall) begin
            rd_req_ready = 1'b0;
            @(negedge clk);
            check("stall_valid", rd_req_valid, 1'b1);
            check("stall_addr", rd_req_addr, exp_addr);
            check("stall_len", rd_req_len, exp_len);
        end
        rd_req_ready = 1'b1;
        @(negedge clk);
        rd_req_ready = 1'b0;
        check("req_single", rd_req_valid, 1'b0);
    endtask

    task automatic run_load(input logic [31:0] base, input int words, input int stall0,
                            input bit wait_rel);
        int          n, rem, len, wr0, t;
        bit          first;
        logic [31:0] a;
        n          = (words > 1024) ? 1024 : words;
        desc_valid = 1'b1;
        desc_base  = base;
        desc_words = 11'(words);
        if (wait_rel) begin
            repeat (4) begin
                check("desc_held", desc_ready, 1'b0);
                @(negedge clk);
            end
            do_release();
            check("ready_after_rel", desc_ready, 1'b1);
        end
        t = 0;
        while (desc_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (desc_ready !== 1'b1) begin
            $display("FAIL desc_timeout: got desc_ready=%0b expected 1", desc_ready);
            $fatal(1, "descriptor timeout");
        end
        @(negedge clk);
        desc_valid = 1'b0;
        idx_m      = 0;
        wr0        = wr_count;
        check("busy_load", busy, 1'b1);
        if (n == 0) begin
            check("zero_no_req", rd_req_valid, 1'b0);
            check("zero_pre_mark", {bufB_loaded, bufA_loaded}, loaded_m);
            @(negedge clk);
        end else begin
            rem   = n;
            a     = base;
            first = 1'b1;
            while (rem > 0) begin
                len = (rem > 16) ? 16 : rem;
                serve_req(a, len, first ? stall0 : int'($urandom_range(0, 2)));
                first = 1'b0;
                for (int b = 0; b < len; b++) send_beat(int'($urandom_range(0, 1)));
                a   = a + 32'(len * 8);
                rem = rem - len;
            end
            check("pre_mark", {bufB_loaded, bufA_loaded}, loaded_m);
            @(negedge clk);
        end
        loaded_m[fill_m] = 1'b1;
        fill_m           = ~fill_m;
        check("loaded", {bufB_loaded, bufA_loaded}, loaded_m);
        check("idle_busy", busy, 1'b0);
        check("ready_reeval", desc_ready, !loaded_m[fill_m]);
        check("no_err", err, 1'b0);
        check("wr_count", wr_count - wr0, n);
    endtask

    initial begin
        rst           = 1'b1;
        desc_valid    = 1'b0;
        desc_base     = '0;
        desc_words    = '0;
        rd_req_ready  = 1'b0;
        rd_data_valid = 1'b0;
        rd_data       = '0;
        layer_done    = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_desc_ready", desc_ready, 1'b0);
        check("rst_req_valid", rd_req_valid, 1'b0);
        check("rst_we", wbuf_we, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_loaded", {bufB_loaded, bufA_loaded}, 2'b00);
        check("rst_err", err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", desc_ready, 1'b1);
        check("post_rst_wdata", wbuf_wdata, 64'h0);

        // Protocol errors while empty and idle
        do_release();
        stray_beat();
        @(negedge clk);
        check("err_one_cycle", err, 1'b0);

        // Single load with a 7-cycle backpressured first request, then ping-pong
        run_load(32'h0000_1000, 40, 7, 1'b0);
        run_load($urandom & 32'hFFFF_FFF8, int'($urandom_range(1, 60)), 1, 1'b0);
        run_load($urandom & 32'hFFFF_FFF8, 33, 1, 1'b1);
        do_release();
        do_release();

        // Saturation, zero length, address wrap
        run_load(32'h2000_0000, 1500, 0, 1'b0);
        run_load(32'h0000_0040, 0, 0, 1'b0);
        do_release();
        do_release();
        run_load(32'hFFFF_FFC0, 20, 2, 1'b0);

        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 2) == 0) do_release();
            run_load($urandom & 32'hFFFF_FFF8, int'($urandom_range(0, 70)),
                     int'($urandom_range(0, 3)), loaded_m[fill_m]);
        end

        // Reset in the middle of a burst
        while (loaded_m != 2'b00) do_release();
        desc_valid = 1'b1;
        desc_base  = 32'h0000_5000;
        desc_words = 11'd16;
        @(negedge clk);
        desc_valid = 1'b0;
        idx_m      = 0;
        serve_req(32'h0000_5000, 16, 0);
        for (int b = 0; b < 5; b++) send_beat(0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req", rd_req_valid, 1'b0);
        check("midrst_we", wbuf_we, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", desc_ready, 1'b0);
        check("midrst_loaded", {bufB_loaded, bufA_loaded}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int b = 0; b < 11; b++) stray_beat();
        check("after_rst_loaded", {bufB_loaded, bufA_loaded}, 2'b00);
        run_load(32'h0000_3000, 20, 0, 1'b0);

        repeat (3) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
